// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port data memory between the instruction
// fetch unit (read-only) and the load/store unit (read/write).
//
// One request is in flight at a time:
//   aligned    : IDLE -> ACCESS -> WAIT -> RESP -> IDLE
//   misaligned : IDLE -> RESP -> IDLE   (memory is never enabled)
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clk edge where valid and ready are both high. req_ready is only ever high
// in IDLE, for the granted requester, and is a combinational function of the
// req_valid inputs. resp_valid holds, with rdata/err stable, until the
// owner's resp_ready is seen high on an edge.
//
// dbg_state exposes the FSM state (0 IDLE, 1 ACCESS, 2 WAIT, 3 RESP).
module mem_arbiter #(
    parameter int         ADDR_W   = 64,
    parameter int         DATA_W   = 64,
    parameter int         ARB_MODE = 0,
    parameter logic [3:0] IFU_MASK = 4'b0010
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    // load/store port
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [3:0]        lsu_mask,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    // memory port
    output logic              mem_ena,
    output logic              mem_wen,
    output logic [3:0]        mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // debug
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    // captured request
    logic              r_owner_lsu;
    logic              r_last_lsu;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [3:0]        r_mask;
    logic [DATA_W-1:0] r_wdata;
    // response buffer
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    // arbitration and request selection
    logic              w_grant_lsu;
    logic              w_grant_ifu;
    logic              w_accept;
    logic              w_resp_taken;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_req_wen;
    logic [3:0]        w_req_mask;
    logic [DATA_W-1:0] w_req_wdata;
    logic              w_req_misaligned;

    // Size mask is one-hot: bit0 8B, bit1 4B, bit2 2B, bit3 1B. An all-zero
    // mask has no defined size and is treated as an error.
    function automatic logic f_misaligned(input logic [3:0] mask, input logic [2:0] lo);
        return (mask == 4'b0000)
            || (mask[0] && (lo != 3'b000))
            || (mask[1] && (lo[1:0] != 2'b00))
            || (mask[2] && lo[0]);
    endfunction

    // Grant: a lone requester wins; on a tie, round-robin picks whoever was
    // not granted last, fixed-priority mode always picks the LSU.
    assign w_grant_lsu = lsu_req_valid &&
                         (!ifu_req_valid || (ARB_MODE == 1) || !r_last_lsu);
    assign w_grant_ifu = ifu_req_valid && !w_grant_lsu;
    assign w_accept    = (r_state == S_IDLE) && (w_grant_lsu || w_grant_ifu);
    assign w_resp_taken = r_owner_lsu ? lsu_resp_ready : ifu_resp_ready;

    // Select the payload of the granted requester; IFU fetches are fixed-size reads.
    always_comb begin
        w_req_addr  = ifu_addr;
        w_req_wen   = 1'b0;
        w_req_mask  = IFU_MASK;
        w_req_wdata = '0;
        if (w_grant_lsu) begin
            w_req_addr  = lsu_addr;
            w_req_wen   = lsu_wen;
            w_req_mask  = lsu_mask;
            w_req_wdata = lsu_wdata;
        end
        w_req_misaligned = f_misaligned(w_req_mask, w_req_addr[2:0]);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_req_misaligned ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: w_next_state = S_WAIT;
            S_WAIT:   w_next_state = S_RESP;
            S_RESP: begin
                if (w_resp_taken) begin
                    w_next_state = S_IDLE;
                end
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Capture the request on the accept edge and the read data at the end of WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_lsu <= 1'b0;
            r_last_lsu  <= 1'b0;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_mask      <= 4'b0000;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else if (w_accept) begin
            r_owner_lsu <= w_grant_lsu;
            r_last_lsu  <= w_grant_lsu;
            r_addr      <= w_req_addr;
            r_wen       <= w_req_wen;
            r_mask      <= w_req_mask;
            r_wdata     <= w_req_wdata;
            r_rdata     <= '0;
            r_err       <= w_req_misaligned;
        end else if (r_state == S_WAIT) begin
            // stores acknowledge with zero data
            r_rdata <= r_wen ? '0 : mem_rdata;
        end
    end

    // FSM outputs: readies in IDLE, memory drive in ACCESS, owner response in RESP.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;
        mem_ena        = 1'b0;
        mem_wen        = 1'b0;
        mem_mask       = 4'b0000;
        mem_addr       = '0;
        mem_wdata      = '0;
        dbg_state      = r_state;
        case (r_state)
            S_IDLE: begin
                // held low while reset is asserted so every output reads 0
                ifu_req_ready = rst_n && w_grant_ifu;
                lsu_req_ready = rst_n && w_grant_lsu;
            end
            S_ACCESS: begin
                mem_ena   = 1'b1;
                mem_wen   = r_wen;
                mem_mask  = r_mask;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
            end
            S_RESP: begin
                if (r_owner_lsu) begin
                    lsu_resp_valid = 1'b1;
                    lsu_rdata      = r_rdata;
                    lsu_resp_err   = r_err;
                end else begin
                    ifu_resp_valid = 1'b1;
                    ifu_rdata      = r_rdata;
                    ifu_resp_err   = r_err;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. dut_a runs round-robin (ARB_MODE 0),
// dut_b runs fixed priority (ARB_MODE 1). Inputs change #1 after the rising
// edge; outputs are sampled on the falling edge.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // ---------------- dut_a signals ----------------
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [3:0]  lsu_mask;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_ena, mem_wen;
    logic [3:0]  mem_mask;
    logic [63:0] mem_addr, mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic [1:0]  dbg_state;

    // ---------------- dut_b signals ----------------
    logic        ifu_req_valid_b, ifu_req_ready_b, ifu_resp_valid_b, ifu_resp_ready_b, ifu_resp_err_b;
    logic [63:0] ifu_addr_b, ifu_rdata_b;
    logic        lsu_req_valid_b, lsu_req_ready_b, lsu_wen_b, lsu_resp_valid_b, lsu_resp_ready_b, lsu_resp_err_b;
    logic [3:0]  lsu_mask_b;
    logic [63:0] lsu_addr_b, lsu_wdata_b, lsu_rdata_b;
    logic        mem_ena_b, mem_wen_b;
    logic [3:0]  mem_mask_b;
    logic [63:0] mem_addr_b, mem_wdata_b;
    logic [63:0] mem_rdata_b = '0;
    logic [1:0]  dbg_state_b;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .ARB_MODE(0), .IFU_MASK(4'b0010)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_mask(lsu_mask), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_ena(mem_ena), .mem_wen(mem_wen), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .ARB_MODE(1), .IFU_MASK(4'b0010)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid_b), .ifu_req_ready(ifu_req_ready_b), .ifu_addr(ifu_addr_b),
        .ifu_resp_valid(ifu_resp_valid_b), .ifu_resp_ready(ifu_resp_ready_b),
        .ifu_rdata(ifu_rdata_b), .ifu_resp_err(ifu_resp_err_b),
        .lsu_req_valid(lsu_req_valid_b), .lsu_req_ready(lsu_req_ready_b), .lsu_wen(lsu_wen_b),
        .lsu_mask(lsu_mask_b), .lsu_addr(lsu_addr_b), .lsu_wdata(lsu_wdata_b),
        .lsu_resp_valid(lsu_resp_valid_b), .lsu_resp_ready(lsu_resp_ready_b),
        .lsu_rdata(lsu_rdata_b), .lsu_resp_err(lsu_resp_err_b),
        .mem_ena(mem_ena_b), .mem_wen(mem_wen_b), .mem_mask(mem_mask_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .dbg_state(dbg_state_b)
    );

    // Memory model: fixed contents, one-cycle read latency.
    function automatic logic [63:0] mem_f(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0000_0000_0013;
        return {~a[31:0], a[31:0]};
    endfunction

    always @(posedge clk) if (mem_ena)   mem_rdata   <= mem_f(mem_addr);
    always @(posedge clk) if (mem_ena_b) mem_rdata_b <= mem_f(mem_addr_b);

    // Misalignment vectors: mask, low address bits, expected err.
    logic [3:0] mis_mask [0:5] = '{4'b0100, 4'b0000, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
    logic [2:0] mis_lo   [0:5] = '{3'd3,    3'd0,    3'd4,    3'd2,    3'd7,    3'd2};
    logic       mis_err  [0:5] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0};
    // Round-robin grant order starting from reset (1 = LSU).
    logic       rr_lsu   [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 0;
        lsu_req_valid = 0; lsu_wen = 0; lsu_mask = '0; lsu_addr = '0; lsu_wdata = '0; lsu_resp_ready = 0;
        ifu_req_valid_b = 0; ifu_addr_b = '0; ifu_resp_ready_b = 0;
        lsu_req_valid_b = 0; lsu_wen_b = 0; lsu_mask_b = '0; lsu_addr_b = '0; lsu_wdata_b = '0; lsu_resp_ready_b = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        neg();
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ena: got %0b want 0", mem_ena); end
        n_total++; if (mem_addr !== 64'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        n_total++; if (lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lsu_resp: got %0b want 0", lsu_resp_valid); end
        n_total++; if (dbg_state_b !== 2'd0) begin n_bad++; $display("FAIL reset_state_b: got %0d want 0", dbg_state_b); end
        cyc();
        rst_n = 1;
        neg();
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL post_reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_ifu_fetch();
        cyc();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 0;
        neg();
        n_total++; if (ifu_req_ready !== 1'b1) begin n_bad++; $display("FAIL fetch_ready: got %0b want 1", ifu_req_ready); end
        n_total++; if (lsu_req_ready !== 1'b0) begin n_bad++; $display("FAIL fetch_lsu_ready: got %0b want 0", lsu_req_ready); end
        cyc();
        ifu_req_valid = 0; ifu_addr = '0;
        neg();
        n_total++; if (mem_ena !== 1'b1) begin n_bad++; $display("FAIL fetch_ena: got %0b want 1", mem_ena); end
        n_total++; if (mem_mask !== 4'b0010) begin n_bad++; $display("FAIL fetch_mask: got %0b want 0010", mem_mask); end
        n_total++; if (mem_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL fetch_addr: got %0h want 80000000", mem_addr); end
        n_total++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL fetch_wen: got %0b want 0", mem_wen); end
        cyc(); neg();
        n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL fetch_wait_ena: got %0b want 0", mem_ena); end
        n_total++; if (ifu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_early_resp: got %0b want 0", ifu_resp_valid); end
        cyc(); neg();
        n_total++; if (ifu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL fetch_resp_valid: got %0b want 1", ifu_resp_valid); end
        n_total++; if (ifu_rdata !== 64'h13) begin n_bad++; $display("FAIL fetch_rdata: got %0h want 13", ifu_rdata); end
        n_total++; if (ifu_resp_err !== 1'b0) begin n_bad++; $display("FAIL fetch_err: got %0b want 0", ifu_resp_err); end
        n_total++; if (lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_lsu_resp: got %0b want 0", lsu_resp_valid); end
        ifu_resp_ready = 1;
        cyc();
        ifu_resp_ready = 0;
        neg();
        n_total++; if (ifu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL fetch_resp_done: got %0b want 0", ifu_resp_valid); end
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL fetch_idle: got %0d want 0", dbg_state); end
    endtask

    task automatic test_lsu_store();
        cyc();
        lsu_req_valid = 1; lsu_wen = 1; lsu_mask = 4'b0010; lsu_addr = 64'h8000_0104;
        lsu_wdata = 64'hDEAD_BEEF_0000_0000; lsu_resp_ready = 1;
        neg();
        n_total++; if (lsu_req_ready !== 1'b1) begin n_bad++; $display("FAIL store_ready: got %0b want 1", lsu_req_ready); end
        n_total++; if (ifu_req_ready !== 1'b0) begin n_bad++; $display("FAIL store_ifu_ready: got %0b want 0", ifu_req_ready); end
        cyc();
        lsu_req_valid = 0; lsu_wen = 0;
        neg();
        n_total++; if (mem_ena !== 1'b1) begin n_bad++; $display("FAIL store_ena: got %0b want 1", mem_ena); end
        n_total++; if (mem_wen !== 1'b1) begin n_bad++; $display("FAIL store_wen: got %0b want 1", mem_wen); end
        n_total++; if (mem_mask !== 4'b0010) begin n_bad++; $display("FAIL store_mask: got %0b want 0010", mem_mask); end
        n_total++; if (mem_addr !== 64'h8000_0104) begin n_bad++; $display("FAIL store_addr: got %0h want 80000104", mem_addr); end
        n_total++; if (mem_wdata !== 64'hDEAD_BEEF_0000_0000) begin n_bad++; $display("FAIL store_wdata: got %0h want deadbeef00000000", mem_wdata); end
        cyc(); neg();
        n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL store_wait_ena: got %0b want 0", mem_ena); end
        n_total++; if (mem_wdata !== 64'h0) begin n_bad++; $display("FAIL store_wait_wdata: got %0h want 0", mem_wdata); end
        cyc(); neg();
        n_total++; if (lsu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL store_resp_valid: got %0b want 1", lsu_resp_valid); end
        n_total++; if (lsu_rdata !== 64'h0) begin n_bad++; $display("FAIL store_rdata: got %0h want 0", lsu_rdata); end
        n_total++; if (lsu_resp_err !== 1'b0) begin n_bad++; $display("FAIL store_err: got %0b want 0", lsu_resp_err); end
        n_total++; if (ifu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL store_ifu_resp: got %0b want 0", ifu_resp_valid); end
        cyc();
        lsu_resp_ready = 0;
        neg();
        n_total++; if (lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL store_resp_done: got %0b want 0", lsu_resp_valid); end
    endtask

    task automatic test_misaligned();
        for (int v = 0; v < 6; v++) begin
            logic [63:0] a;
            a = 64'h8000_0000 | {61'd0, mis_lo[v]};
            cyc();
            lsu_req_valid = 1; lsu_wen = 0; lsu_mask = mis_mask[v]; lsu_addr = a; lsu_resp_ready = 0;
            neg();
            n_total++; if (lsu_req_ready !== 1'b1) begin n_bad++; $display("FAIL mis_ready[%0d]: got %0b want 1", v, lsu_req_ready); end
            cyc();
            lsu_req_valid = 0;
            neg();
            if (mis_err[v]) begin
                n_total++; if (lsu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL mis_resp_valid[%0d]: got %0b want 1", v, lsu_resp_valid); end
                n_total++; if (lsu_resp_err !== 1'b1) begin n_bad++; $display("FAIL mis_err[%0d]: got %0b want 1", v, lsu_resp_err); end
                n_total++; if (lsu_rdata !== 64'h0) begin n_bad++; $display("FAIL mis_rdata[%0d]: got %0h want 0", v, lsu_rdata); end
                n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL mis_ena[%0d]: got %0b want 0", v, mem_ena); end
            end else begin
                n_total++; if (mem_ena !== 1'b1) begin n_bad++; $display("FAIL ali_ena[%0d]: got %0b want 1", v, mem_ena); end
                n_total++; if (lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL ali_early[%0d]: got %0b want 0", v, lsu_resp_valid); end
                cyc(); cyc(); neg();
                n_total++; if (lsu_resp_err !== 1'b0) begin n_bad++; $display("FAIL ali_err[%0d]: got %0b want 0", v, lsu_resp_err); end
                n_total++; if (lsu_rdata !== mem_f(a)) begin n_bad++; $display("FAIL ali_rdata[%0d]: got %0h want %0h", v, lsu_rdata, mem_f(a)); end
            end
            lsu_resp_ready = 1;
            cyc();
            lsu_resp_ready = 0;
            neg();
            n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL mis_idle[%0d]: got %0d want 0", v, dbg_state); end
        end
    endtask

    task automatic test_backpressure_reset();
        cyc();
        lsu_req_valid = 1; lsu_wen = 0; lsu_mask = 4'b0001; lsu_addr = 64'h8000_0200; lsu_resp_ready = 0;
        neg();
        n_total++; if (lsu_req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready: got %0b want 1", lsu_req_ready); end
        cyc();
        // next request is presented immediately and must wait
        lsu_req_valid = 1; lsu_wen = 1; lsu_mask = 4'b0001; lsu_addr = 64'h8000_0300; lsu_wdata = 64'h1122_3344_5566_7788;
        neg();
        n_total++; if (mem_addr !== 64'h8000_0200) begin n_bad++; $display("FAIL bp_addr: got %0h want 80000200", mem_addr); end
        n_total++; if (lsu_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_access: got %0b want 0", lsu_req_ready); end
        cyc(); cyc(); neg();
        n_total++; if (lsu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_resp_valid: got %0b want 1", lsu_resp_valid); end
        for (int i = 0; i < 5; i++) begin
            cyc(); neg();
            n_total++; if (lsu_resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", i, lsu_resp_valid); end
            n_total++; if (lsu_rdata !== 64'h7FFF_FDFF_8000_0200) begin n_bad++; $display("FAIL bp_hold_rdata[%0d]: got %0h want 7ffffdff80000200", i, lsu_rdata); end
            n_total++; if (lsu_req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_no_grant[%0d]: got %0b want 0", i, lsu_req_ready); end
            n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL bp_ena[%0d]: got %0b want 0", i, mem_ena); end
        end
        lsu_resp_ready = 1;
        cyc();
        lsu_resp_ready = 0;
        neg();
        n_total++; if (lsu_req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_resume_ready: got %0b want 1", lsu_req_ready); end
        cyc();
        lsu_req_valid = 0; lsu_wen = 0;
        n_total++; if (mem_wdata !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL rst_pre_wdata: got %0h want 1122334455667788", mem_wdata); end
        rst_n = 0;
        #1;
        n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL rst_ena: got %0b want 0", mem_ena); end
        n_total++; if (mem_wen !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %0b want 0", mem_wen); end
        n_total++; if (mem_addr !== 64'h0) begin n_bad++; $display("FAIL rst_addr: got %0h want 0", mem_addr); end
        n_total++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        neg();
        cyc();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            neg();
            n_total++; if (lsu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_resp[%0d]: got %0b want 0", i, lsu_resp_valid); end
            n_total++; if (mem_ena !== 1'b0) begin n_bad++; $display("FAIL rst_no_ena[%0d]: got %0b want 0", i, mem_ena); end
            cyc();
        end
    endtask

    task automatic test_round_robin();
        ifu_req_valid = 1; ifu_addr = 64'h8000_0010; ifu_resp_ready = 1;
        lsu_req_valid = 1; lsu_wen = 0; lsu_mask = 4'b0001; lsu_addr = 64'h8000_0020; lsu_resp_ready = 1;
        for (int i = 0; i < 16; i++) begin
            int ph;
            int tx;
            ph = i % 4;
            tx = i / 4;
            neg();
            n_total++; if (mem_ena !== (ph == 1)) begin n_bad++; $display("FAIL rr_ena[%0d]: got %0b want %0b", i, mem_ena, ph == 1); end
            if (ph == 0) begin
                n_total++; if (lsu_req_ready !== rr_lsu[tx]) begin n_bad++; $display("FAIL rr_lsu_grant[%0d]: got %0b want %0b", tx, lsu_req_ready, rr_lsu[tx]); end
                n_total++; if (ifu_req_ready !== !rr_lsu[tx]) begin n_bad++; $display("FAIL rr_ifu_grant[%0d]: got %0b want %0b", tx, ifu_req_ready, !rr_lsu[tx]); end
            end else if (ph == 1) begin
                n_total++; if (mem_addr !== (rr_lsu[tx] ? 64'h8000_0020 : 64'h8000_0010)) begin n_bad++; $display("FAIL rr_addr[%0d]: got %0h", tx, mem_addr); end
            end else if (ph == 3) begin
                n_total++; if (lsu_resp_valid !== rr_lsu[tx]) begin n_bad++; $display("FAIL rr_lsu_resp[%0d]: got %0b want %0b", tx, lsu_resp_valid, rr_lsu[tx]); end
                if (rr_lsu[tx]) begin
                    n_total++; if (lsu_rdata !== 64'h7FFF_FFDF_8000_0020) begin n_bad++; $display("FAIL rr_lsu_rdata[%0d]: got %0h want 7fffffdf80000020", tx, lsu_rdata); end
                end else begin
                    n_total++; if (ifu_rdata !== 64'h7FFF_FFEF_8000_0010) begin n_bad++; $display("FAIL rr_ifu_rdata[%0d]: got %0h want 7fffffef80000010", tx, ifu_rdata); end
                end
            end
            cyc();
        end
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        ifu_req_valid_b = 1; ifu_addr_b = 64'h8000_0010; ifu_resp_ready_b = 1;
        lsu_req_valid_b = 1; lsu_wen_b = 0; lsu_mask_b = 4'b0001; lsu_addr_b = 64'h8000_0020; lsu_resp_ready_b = 1;
        for (int i = 0; i < 12; i++) begin
            neg();
            n_total++; if (ifu_req_ready_b !== 1'b0) begin n_bad++; $display("FAIL fp_ifu_starved_ok[%0d]: got %0b want 0", i, ifu_req_ready_b); end
            if (i % 4 == 0) begin
                n_total++; if (lsu_req_ready_b !== 1'b1) begin n_bad++; $display("FAIL fp_lsu_grant[%0d]: got %0b want 1", i, lsu_req_ready_b); end
            end
            cyc();
        end
        lsu_req_valid_b = 0;
        neg();
        n_total++; if (ifu_req_ready_b !== 1'b1) begin n_bad++; $display("FAIL fp_ifu_grant: got %0b want 1", ifu_req_ready_b); end
        cyc();
        ifu_req_valid_b = 0;
        cyc(); cyc(); neg();
        n_total++; if (ifu_rdata_b !== 64'h7FFF_FFEF_8000_0010) begin n_bad++; $display("FAIL fp_ifu_rdata: got %0h want 7fffffef80000010", ifu_rdata_b); end
        cyc();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_lsu_store();
        test_misaligned();
        test_backpressure_reset();
        test_round_robin();
        test_fixed_priority();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
